// File: rtl/rom_bist_misr_ctrl_if.sv
// Bundle between the ROM BIST initiator and the wrapper BIST plane / DFX status logic.
// BIST_SIG_OUT exists only when ROM_BIST_SIG_OUT_EN is defined.
interface rom_bist_misr_ctrl_if #(
    parameter int ROM_ADDR = 11,
    parameter int ROM_BITS = 32
);
    logic                BIST_START;
    logic [ROM_BITS-1:0] BIST_EXP_SIG;
    logic [ROM_BITS-1:0] DATA_ROM_IN;
    logic                BIST_ROM_ENABLE;
    logic [ROM_ADDR-1:0] BIST_ADDR_ROM;
    logic                BIST_REN_ROM;
    logic                BIST_BUSY;
    logic                BIST_DONE;
    logic                BIST_PASS;
`ifdef ROM_BIST_SIG_OUT_EN
    logic [ROM_BITS-1:0] BIST_SIG_OUT;
`endif

    modport master (
`ifdef ROM_BIST_SIG_OUT_EN
        output BIST_SIG_OUT,
`endif
        input  BIST_START, BIST_EXP_SIG, DATA_ROM_IN,
        output BIST_ROM_ENABLE, BIST_ADDR_ROM, BIST_REN_ROM,
        output BIST_BUSY, BIST_DONE, BIST_PASS
    );

    modport slave (
`ifdef ROM_BIST_SIG_OUT_EN
        input  BIST_SIG_OUT,
`endif
        output BIST_START, BIST_EXP_SIG, DATA_ROM_IN,
        input  BIST_ROM_ENABLE, BIST_ADDR_ROM, BIST_REN_ROM,
        input  BIST_BUSY, BIST_DONE, BIST_PASS
    );
endinterface

// File: rtl/rom_bist_misr_ctrl.sv
// ROM MBIST initiator: settle, sweep all addresses one read per clock, MISR-compress, compare.
// Optional ROM_BIST_SIG_OUT_EN exposes the final MISR value on BIST_SIG_OUT.
//
// state     | meaning
// S_IDLE    | waiting for BIST_START, BIST plane released
// S_SETTLE  | BIST_ROM_ENABLE high, clock mux settling, no reads
// S_READ    | one read per cycle, address counter sweeping
// S_DRAIN   | reads finished, waiting for in-flight data
// S_COMPARE | MISR compared against BIST_EXP_SIG
// S_DONE    | result valid, BIST_START begins a new run
module rom_bist_misr_ctrl #(
    parameter int                  ROM_ADDR   = 11,
    parameter int                  ROM_WORDS  = 2048,
    parameter int                  ROM_BITS   = 32,
    parameter int                  RD_LATENCY = 1,
    parameter int                  SETTLE_CYC = 4,
    parameter logic [ROM_BITS-1:0] MISR_POLY  = 32'h04C11DB7,
    parameter logic [ROM_BITS-1:0] MISR_SEED  = 32'h0
) (
    input logic                  BIST_CLK_ROM_IN,
    input logic                  BIST_RST_B_ROM_IN,
    rom_bist_misr_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_READ, S_DRAIN, S_COMPARE, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic                  en_q, en_d, ren_q, ren_d, busy_q, busy_d, done_q, done_d;
    logic                  pass_q;
    logic [ROM_ADDR-1:0]   addr_q;
    logic [3:0]            settle_cnt_q;
    logic [2:0]            drain_cnt_q;
    logic [RD_LATENCY-1:0] vld_q;
    logic [ROM_BITS-1:0]   misr_q, misr_d;
    logic                  run_start, settle_last, addr_last, drain_last;

    assign run_start   = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus.BIST_START;
    assign settle_last = (settle_cnt_q == 4'(SETTLE_CYC - 1));
    assign addr_last   = (addr_q == ROM_ADDR'(ROM_WORDS - 1));
    assign drain_last  = (drain_cnt_q == 3'(RD_LATENCY - 1));

    always_ff @(posedge BIST_CLK_ROM_IN or negedge BIST_RST_B_ROM_IN) begin
        if (!BIST_RST_B_ROM_IN) state_q <= S_IDLE;
        else                    state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (bus.BIST_START) state_d = S_SETTLE;
            S_SETTLE:       if (settle_last)    state_d = S_READ;
            S_READ:         if (addr_last)      state_d = S_DRAIN;
            S_DRAIN:        if (drain_last)     state_d = S_COMPARE;
            S_COMPARE:                          state_d = S_DONE;
            default:                            state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registers line up with the state they describe.
    always_comb begin
        en_d   = 1'b0;
        ren_d  = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            S_SETTLE, S_DRAIN, S_COMPARE: begin
                en_d   = 1'b1;
                busy_d = 1'b1;
            end
            S_READ: begin
                en_d   = 1'b1;
                busy_d = 1'b1;
                ren_d  = 1'b1;
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge BIST_CLK_ROM_IN or negedge BIST_RST_B_ROM_IN) begin
        if (!BIST_RST_B_ROM_IN) begin
            en_q   <= 1'b0;
            ren_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            en_q   <= en_d;
            ren_q  <= ren_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Galois MISR step; the shifted-out MSB only selects the polynomial.
    assign misr_d = ({misr_q[ROM_BITS-2:0], 1'b0} ^ (misr_q[ROM_BITS-1] ? MISR_POLY : '0))
                    ^ bus.DATA_ROM_IN;

    always_ff @(posedge BIST_CLK_ROM_IN or negedge BIST_RST_B_ROM_IN) begin
        if (!BIST_RST_B_ROM_IN) begin
            addr_q       <= '0;
            settle_cnt_q <= '0;
            drain_cnt_q  <= '0;
            vld_q        <= '0;
            misr_q       <= MISR_SEED;
            pass_q       <= 1'b0;
        end else begin
            vld_q[0] <= ren_q;
            for (int i = 1; i < RD_LATENCY; i++) vld_q[i] <= vld_q[i-1];

            if (run_start) begin
                addr_q       <= '0;
                settle_cnt_q <= '0;
                drain_cnt_q  <= '0;
                misr_q       <= MISR_SEED;
                pass_q       <= 1'b0;
            end else begin
                if (vld_q[RD_LATENCY-1]) misr_q <= misr_d;
                case (state_q)
                    S_SETTLE:  if (!settle_last) settle_cnt_q <= settle_cnt_q + 4'd1;
                    S_READ:    if (!addr_last)   addr_q       <= addr_q + ROM_ADDR'(1);
                    S_DRAIN:   if (!drain_last)  drain_cnt_q  <= drain_cnt_q + 3'd1;
                    S_COMPARE: pass_q <= (misr_q == bus.BIST_EXP_SIG);
                    default:   ;
                endcase
            end
        end
    end

`ifdef ROM_BIST_SIG_OUT_EN
    logic [ROM_BITS-1:0] sig_q;

    always_ff @(posedge BIST_CLK_ROM_IN or negedge BIST_RST_B_ROM_IN) begin
        if (!BIST_RST_B_ROM_IN)        sig_q <= MISR_SEED;
        else if (run_start)            sig_q <= MISR_SEED;
        else if (state_q == S_COMPARE) sig_q <= misr_q;
    end

    assign bus.BIST_SIG_OUT = sig_q;
`endif

    assign bus.BIST_ROM_ENABLE = en_q;
    assign bus.BIST_ADDR_ROM   = addr_q;
    assign bus.BIST_REN_ROM    = ren_q;
    assign bus.BIST_BUSY       = busy_q;
    assign bus.BIST_DONE       = done_q;
    assign bus.BIST_PASS       = pass_q;
endmodule
